// File: rtl/uart_pkg.sv
// Shared constants, status codes and FSM state type for the UART register responder.
package uart_pkg;

  localparam logic [7:0] SYNC_REQ = 8'hA5;
  localparam logic [7:0] SYNC_RSP = 8'h5A;
  localparam logic [7:0] CMD_RD   = 8'h01;
  localparam logic [7:0] CMD_WR   = 8'h02;

  localparam logic [7:0] ST_OK    = 8'h00;
  localparam logic [7:0] ST_CSUM  = 8'h01;
  localparam logic [7:0] ST_CMD   = 8'h02;
  localparam logic [7:0] ST_ADDR  = 8'h03;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_CSUM,
    S_EXEC,
    S_TX_WAIT,
    S_TX_PULSE,
    S_TX_GAP,
    S_TX_DRAIN
  } state_t;

  function automatic logic [7:0] rsp_byte(input logic [1:0] idx,
                                          input logic [7:0] status,
                                          input logic [7:0] rdata);
    case (idx)
      2'd0:    rsp_byte = SYNC_RSP;
      2'd1:    rsp_byte = status;
      2'd2:    rsp_byte = rdata;
      default: rsp_byte = status ^ rdata;
    endcase
  endfunction

endpackage

// File: rtl/uart_reg_responder_if.sv
// Byte-level handshake bundle between the UART and the register responder.
interface uart_reg_responder_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_read;
  logic       tx_busy;
  logic       tx_write;
  logic [7:0] tx_data;
  logic [7:0] ctrl_out;
  logic       frame_err;

  modport master (
    output rx_valid, rx_data, tx_busy,
    input  rx_read, tx_write, tx_data, ctrl_out, frame_err
  );

  modport slave (
    input  rx_valid, rx_data, tx_busy,
    output rx_read, tx_write, tx_data, ctrl_out, frame_err
  );
endinterface

// File: rtl/uart_reg_file.sv
// REG_DEPTH x 8 register file: synchronous write, asynchronous read, register 0 tapped out.
module uart_reg_file #(
  parameter int REG_DEPTH = 16,
  parameter int AW        = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata,
  output logic [7:0]    o_reg0
);

  logic [7:0] r_mem [REG_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_DEPTH; i++) r_mem[i] <= 8'h00;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
  assign o_reg0  = r_mem[0];

endmodule

// File: rtl/uart_reg_responder.sv
// Parses A5-framed read/write commands from the UART and answers with a 4-byte 5A frame.
//   state      | meaning
//   S_IDLE     | hunt for 0xA5, discard anything else
//   S_CMD      | capture command byte
//   S_ADDR     | capture address byte
//   S_DATA     | capture write data (write command only)
//   S_CSUM     | capture checksum byte
//   S_EXEC     | one cycle: status, register access, latch response
//   S_TX_WAIT  | wait for transmitter idle
//   S_TX_PULSE | tx_write pulse for byte r_idx
//   S_TX_GAP   | let tx_busy rise
//   S_TX_DRAIN | wait for byte to finish, then next byte or idle
module uart_reg_responder
  import uart_pkg::*;
#(
  parameter int REG_DEPTH      = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic                 clk,
  input logic                 reset,
  uart_reg_responder_if.slave bus
);

  localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        r_state, w_next;
  logic          r_rx_read;
  logic [7:0]    r_cmd, r_addr, r_data, r_csum;
  logic [7:0]    r_status, r_rdata;
  logic [1:0]    r_idx;
  logic [TW-1:0] r_to_cnt;

  logic       w_frame, w_timeout, w_take, w_we, w_addr_bad;
  logic [7:0] w_sum, w_status, w_exec_rdata, w_reg_rdata;
  logic       w_tx_write, w_frame_err;
  logic [7:0] w_tx_data;

  assign w_frame   = (r_state == S_CMD) || (r_state == S_ADDR) ||
                     (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_timeout = w_frame && (r_to_cnt == TW'(TIMEOUT_CYCLES));
  // A byte is never captured in the cycle rx_read is already high.
  assign w_take    = ((r_state == S_IDLE) || w_frame) && bus.rx_valid &&
                     !r_rx_read && !w_timeout;

  assign w_sum      = r_cmd ^ r_addr ^ ((r_cmd == CMD_WR) ? r_data : 8'h00);
  assign w_addr_bad = ({1'b0, r_addr} >= 9'(REG_DEPTH));
  assign w_status   = (w_sum != r_csum)                       ? ST_CSUM :
                      ((r_cmd != CMD_RD) && (r_cmd != CMD_WR)) ? ST_CMD  :
                      w_addr_bad                               ? ST_ADDR : ST_OK;
  assign w_we         = (r_state == S_EXEC) && (w_status == ST_OK) && (r_cmd == CMD_WR);
  assign w_exec_rdata = (w_status != ST_OK) ? 8'h00 :
                        (r_cmd == CMD_WR)   ? r_data : w_reg_rdata;

  uart_reg_file #(.REG_DEPTH(REG_DEPTH), .AW(AW)) u_regs (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (r_addr[AW-1:0]),
    .i_wdata (r_data),
    .i_raddr (r_addr[AW-1:0]),
    .o_rdata (w_reg_rdata),
    .o_reg0  (bus.ctrl_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rx_read <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_rx_read <= w_take;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_take && bus.rx_data == SYNC_REQ) w_next = S_CMD;
      S_CMD:      if (w_take) w_next = S_ADDR;
      S_ADDR:     if (w_take) w_next = (r_cmd == CMD_WR) ? S_DATA : S_CSUM;
      S_DATA:     if (w_take) w_next = S_CSUM;
      S_CSUM:     if (w_take) w_next = S_EXEC;
      S_EXEC:     w_next = S_TX_WAIT;
      S_TX_WAIT:  if (!bus.tx_busy) w_next = S_TX_PULSE;
      S_TX_PULSE: w_next = S_TX_GAP;
      S_TX_GAP:   w_next = S_TX_DRAIN;
      S_TX_DRAIN: if (!bus.tx_busy) w_next = (r_idx == 2'd3) ? S_IDLE : S_TX_WAIT;
      default:    w_next = S_IDLE;
    endcase
    if (w_timeout) w_next = S_IDLE;
  end

  // Outputs are gated by reset so an abort takes effect in the reset cycle itself.
  always_comb begin
    w_tx_write  = (r_state == S_TX_PULSE) && !reset;
    w_tx_data   = w_tx_write ? rsp_byte(r_idx, r_status, r_rdata) : 8'h00;
    w_frame_err = !reset && (w_timeout ||
                  ((r_state == S_EXEC) && (w_status != ST_OK)));
  end

  assign bus.rx_read   = r_rx_read;
  assign bus.tx_write  = w_tx_write;
  assign bus.tx_data   = w_tx_data;
  assign bus.frame_err = w_frame_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd    <= 8'h00;
      r_addr   <= 8'h00;
      r_data   <= 8'h00;
      r_csum   <= 8'h00;
      r_status <= 8'h00;
      r_rdata  <= 8'h00;
      r_idx    <= 2'd0;
      r_to_cnt <= '0;
    end else begin
      if (w_take) begin
        case (r_state)
          S_CMD:   r_cmd  <= bus.rx_data;
          S_ADDR:  r_addr <= bus.rx_data;
          S_DATA:  r_data <= bus.rx_data;
          S_CSUM:  r_csum <= bus.rx_data;
          default: ;
        endcase
      end
      if (!w_frame || w_take) r_to_cnt <= '0;
      else                    r_to_cnt <= r_to_cnt + TW'(1);
      if (r_state == S_EXEC) begin
        r_status <= w_status;
        r_rdata  <= w_exec_rdata;
        r_idx    <= 2'd0;
      end else if (r_state == S_TX_DRAIN && !bus.tx_busy && r_idx != 2'd3) begin
        r_idx <= r_idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Scoreboard bench: a frame-level reference model queues expected response bytes; a monitor checks them.
module tb_uart_reg_responder;

  localparam int DEPTH = 16;
  localparam int TMO   = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_reg_responder_if ifc();
  logic busy_model = 1'b0;
  logic busy_hold  = 1'b0;
  assign ifc.tx_busy = busy_model | busy_hold;

  uart_reg_responder #(.REG_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int         tests = 0;
  int         fails = 0;
  int         tx_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_regs [DEPTH];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every tx_write must match the head of the expected queue.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (ifc.frame_err) err_cnt++;
      if (ifc.tx_write) begin
        tx_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_tx: got 0x%0h, expected no byte at %0t", ifc.tx_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", int'(ifc.tx_data), int'(e));
        end
      end
    end
  end

  // Transmitter model: busy rises the cycle after tx_write and holds a random number of cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (ifc.tx_write) begin
        @(posedge clk);
        #1 busy_model = 1'b1;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 busy_model = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    ifc.rx_valid = 1'b1;
    ifc.rx_data  = b;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ifc.rx_read && n < 3000);
    if (!ifc.rx_read) check("rx_consume_timeout", n, 0);
    ifc.rx_valid = 1'b0;
  endtask

  // Reference model at frame level: status, register update and expected response bytes.
  task automatic model_frame(input logic [7:0] cmd, input logic [7:0] addr,
                             input logic [7:0] data, input logic [7:0] csum,
                             output int exp_err);
    logic [7:0] sum, st, rd;
    sum = cmd ^ addr ^ ((cmd == 8'h02) ? data : 8'h00);
    if (sum != csum)                     st = 8'h01;
    else if (cmd != 8'h01 && cmd != 8'h02) st = 8'h02;
    else if (int'(addr) >= DEPTH)        st = 8'h03;
    else                                 st = 8'h00;
    rd = 8'h00;
    if (st == 8'h00) begin
      if (cmd == 8'h02) begin
        m_regs[int'(addr)] = data;
        rd = data;
      end else begin
        rd = m_regs[int'(addr)];
      end
    end
    exp_q.push_back(8'h5A);
    exp_q.push_back(st);
    exp_q.push_back(rd);
    exp_q.push_back(st ^ rd);
    exp_err = (st != 8'h00) ? 1 : 0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr,
                            input logic [7:0] data, input logic [7:0] csum,
                            output int exp_err);
    model_frame(cmd, addr, data, csum, exp_err);
    send_byte(8'hA5);
    cyc($urandom_range(0, 2));
    send_byte(cmd);
    cyc($urandom_range(0, 2));
    send_byte(addr);
    if (cmd == 8'h02) begin
      cyc($urandom_range(0, 2));
      send_byte(data);
    end
    cyc($urandom_range(0, 2));
    send_byte(csum);
  endtask

  task automatic wait_rsp(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      cyc(1);
      n++;
    end
    if (exp_q.size() != 0) check({name, "_rsp_timeout"}, exp_q.size(), 0);
    cyc(10);
  endtask

  task automatic do_frame(input string name, input logic [7:0] cmd, input logic [7:0] addr,
                          input logic [7:0] data, input logic [7:0] csum);
    int e0, ee;
    e0 = err_cnt;
    send_frame(cmd, addr, data, csum, ee);
    wait_rsp(name);
    check({name, "_frame_err"}, err_cnt - e0, ee);
    check({name, "_ctrl_out"}, int'(ifc.ctrl_out), int'(m_regs[0]));
  endtask

  initial begin
    int t0, e0, ee, n, r;
    logic [7:0] cmd, addr, data, csum;
    for (int i = 0; i < DEPTH; i++) m_regs[i] = 8'h00;
    ifc.rx_valid = 1'b0;
    ifc.rx_data  = 8'h00;

    cyc(3);
    check("rst_rx_read",   int'(ifc.rx_read),   0);
    check("rst_tx_write",  int'(ifc.tx_write),  0);
    check("rst_tx_data",   int'(ifc.tx_data),   0);
    check("rst_frame_err", int'(ifc.frame_err), 0);
    check("rst_ctrl_out",  int'(ifc.ctrl_out),  0);
    reset = 1'b0;
    cyc(2);

    do_frame("wr_reg3",   8'h02, 8'h03, 8'h7E, 8'h7F);
    do_frame("rd_reg3",   8'h01, 8'h03, 8'h00, 8'h02);
    do_frame("wr_reg0",   8'h02, 8'h00, 8'hC3, 8'hC1);
    do_frame("bad_csum",  8'h02, 8'h05, 8'h11, 8'h00);
    do_frame("rd_reg5",   8'h01, 8'h05, 8'h00, 8'h04);
    do_frame("bad_cmd",   8'h07, 8'h00, 8'h00, 8'h07);
    do_frame("bad_addr",  8'h01, 8'h13, 8'h00, 8'h12);
    do_frame("addr_max",  8'h02, 8'h0F, 8'hA5, 8'hA8);
    do_frame("addr_over", 8'h02, 8'h10, 8'h55, 8'h47);

    // Garbage then an abandoned frame: one frame_err, no reply.
    t0 = tx_cnt;
    e0 = err_cnt;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'hA5);
    send_byte(8'h02);
    cyc(TMO + 30);
    check("timeout_frame_err", err_cnt - e0, 1);
    check("timeout_no_tx", tx_cnt - t0, 0);
    do_frame("after_timeout", 8'h01, 8'h03, 8'h00, 8'h02);

    // Backpressure: transmitter held busy for 50 cycles.
    busy_hold = 1'b1;
    e0 = err_cnt;
    send_frame(8'h01, 8'h00, 8'h00, 8'h01, ee);
    t0 = tx_cnt;
    cyc(50);
    check("bp_no_tx_while_busy", tx_cnt - t0, 0);
    busy_hold = 1'b0;
    wait_rsp("bp");
    check("bp_tx_count", tx_cnt - t0, 4);
    check("bp_frame_err", err_cnt - e0, ee);

    // Random traffic against the reference model.
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      cmd  = (r < 4) ? 8'h01 : (r < 8) ? 8'h02 : 8'($urandom_range(0, 255));
      addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                         : 8'($urandom_range(0, DEPTH - 1));
      data = 8'($urandom_range(0, 255));
      csum = cmd ^ addr ^ ((cmd == 8'h02) ? data : 8'h00);
      if ($urandom_range(0, 7) == 0) csum = csum ^ 8'($urandom_range(1, 255));
      do_frame("rand", cmd, addr, data, csum);
    end

    // Reset after the second response byte aborts the reply and clears registers.
    do_frame("pre_rst_wr", 8'h02, 8'h00, 8'h3C, 8'h3E);
    send_frame(8'h01, 8'h00, 8'h00, 8'h01, ee);
    t0 = tx_cnt;
    n = 0;
    while (tx_cnt - t0 < 2 && n < 3000) begin
      cyc(1);
      n++;
    end
    check("rst_mid_tx_reached", tx_cnt - t0, 2);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) m_regs[i] = 8'h00;
    t0 = tx_cnt;
    cyc(30);
    check("rst_no_more_tx", tx_cnt - t0, 0);
    check("rst_ctrl_out_cleared", int'(ifc.ctrl_out), 0);
    for (int a = 0; a < DEPTH; a++) begin
      addr = 8'(a);
      do_frame("rd_after_rst", 8'h01, addr, 8'h00, 8'h01 ^ addr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
